// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter: one instance per requesting port.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 24,
   parameter int unsigned DATA_W = 16
);
   logic              req;
   logic              we;
   logic              lock;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   // Requester drives the transaction, observes grant and read return
   modport master (
      output req, we, lock, addr, wdata,
      input  gnt, rvalid, rdata
   );

   // Arbiter side
   modport slave (
      input  req, we, lock, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port memory with one-cycle
// read latency. Supports bounded locking for read-modify-write sequences.
module mem_arbiter #(
   parameter int unsigned ADDR_W   = 24,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned MAX_LOCK = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_arbiter_if.slave      io_p0,
   mem_arbiter_if.slave      io_p1,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_mem_we,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

   typedef enum logic [1:0] {StIdle, StIssue, StRdata} state_e;

   state_e            r_state;
   logic              r_win;
   logic              r_lock;
   logic              r_last_grant;
   logic              r_lock_active;
   logic              r_owner;
   logic [CNT_W-1:0]  r_lock_cnt;
   logic              r_gnt0;
   logic              r_gnt1;
   logic              r_rvalid0;
   logic              r_rvalid1;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_mem_we;

   logic              w_any;
   logic              w_owner_req;
   logic              w_lock_hold;
   logic              w_winner;
   logic [CNT_W-1:0]  w_cnt_inc;

   // Winner selection: a live lock overrides round-robin, ties go to the port
   // that was not granted last
   always_comb begin
      w_any       = io_p0.req | io_p1.req;
      w_owner_req = r_owner ? io_p1.req : io_p0.req;
      w_lock_hold = r_lock_active && (r_lock_cnt < CNT_W'(MAX_LOCK)) && w_owner_req;
      w_cnt_inc   = r_lock_cnt + CNT_W'(1);
      if (w_lock_hold) begin
         w_winner = r_owner;
      end else if (io_p0.req && io_p1.req) begin
         w_winner = ~r_last_grant;
      end else begin
         w_winner = io_p1.req;
      end
   end

   // Arbitration FSM; every output is registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= StIdle;
         r_win         <= 1'b0;
         r_lock        <= 1'b0;
         r_last_grant  <= 1'b1;
         r_lock_active <= 1'b0;
         r_owner       <= 1'b0;
         r_lock_cnt    <= '0;
         r_gnt0        <= 1'b0;
         r_gnt1        <= 1'b0;
         r_rvalid0     <= 1'b0;
         r_rvalid1     <= 1'b0;
         r_rdata0      <= '0;
         r_rdata1      <= '0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_mem_we      <= 1'b0;
      end else begin
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         unique case (r_state)
            StIdle: begin
               // Owner walked away: drop the lock so the other port is not starved
               if (r_lock_active && !w_owner_req) begin
                  r_lock_active <= 1'b0;
                  r_lock_cnt    <= '0;
               end
               if (w_any) begin
                  r_win       <= w_winner;
                  r_lock      <= w_winner ? io_p1.lock  : io_p0.lock;
                  r_mem_we    <= w_winner ? io_p1.we    : io_p0.we;
                  r_mem_addr  <= w_winner ? io_p1.addr  : io_p0.addr;
                  r_mem_wdata <= w_winner ? io_p1.wdata : io_p0.wdata;
                  r_gnt0      <= ~w_winner;
                  r_gnt1      <= w_winner;
                  r_state     <= StIssue;
               end
            end
            StIssue: begin
               r_gnt0       <= 1'b0;
               r_gnt1       <= 1'b0;
               r_mem_we     <= 1'b0;
               r_mem_addr   <= '0;
               r_mem_wdata  <= '0;
               r_last_grant <= r_win;
               if (r_lock) begin
                  r_owner <= r_win;
                  // Budget exhausted: fall back to round-robin for the next pick
                  if (w_cnt_inc >= CNT_W'(MAX_LOCK)) begin
                     r_lock_active <= 1'b0;
                     r_lock_cnt    <= '0;
                  end else begin
                     r_lock_active <= 1'b1;
                     r_lock_cnt    <= w_cnt_inc;
                  end
               end else begin
                  r_lock_active <= 1'b0;
                  r_lock_cnt    <= '0;
               end
               r_state <= r_mem_we ? StIdle : StRdata;
            end
            StRdata: begin
               if (r_win) begin
                  r_rdata1  <= i_mem_rdata;
                  r_rvalid1 <= 1'b1;
               end else begin
                  r_rdata0  <= i_mem_rdata;
                  r_rvalid0 <= 1'b1;
               end
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign io_p0.gnt    = r_gnt0;
   assign io_p1.gnt    = r_gnt1;
   assign io_p0.rvalid = r_rvalid0;
   assign io_p1.rvalid = r_rvalid1;
   assign io_p0.rdata  = r_rdata0;
   assign io_p1.rdata  = r_rdata1;
   assign o_mem_addr   = r_mem_addr;
   assign o_mem_wdata  = r_mem_wdata;
   assign o_mem_we     = r_mem_we;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single read/write, alternation,
// lock budget, reset during a read, lone back-to-back writer.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] o_mem_addr;
   logic [15:0] o_mem_wdata;
   logic        o_mem_we;
   logic [15:0] i_mem_rdata = '0;

   logic        b_req[2]   = '{1'b0, 1'b0};
   logic        b_we[2]    = '{1'b0, 1'b0};
   logic        b_lock[2]  = '{1'b0, 1'b0};
   logic [23:0] b_addr[2]  = '{24'h0, 24'h0};
   logic [15:0] b_wdata[2] = '{16'h0, 16'h0};

   int          n_chk = 0;
   int          n_bad = 0;
   int          n_both = 0;
   int          n_stray_we = 0;
   int          n_we = 0;
   int          n_rv1 = 0;
   int unsigned cyc = 0;
   int          gq[$];
   int unsigned gt[$];
   logic [15:0] rq0[$];
   logic [15:0] rq1[$];

   mem_arbiter_if #(.ADDR_W(24), .DATA_W(16)) if0 ();
   mem_arbiter_if #(.ADDR_W(24), .DATA_W(16)) if1 ();

   assign if0.req   = b_req[0];
   assign if0.we    = b_we[0];
   assign if0.lock  = b_lock[0];
   assign if0.addr  = b_addr[0];
   assign if0.wdata = b_wdata[0];
   assign if1.req   = b_req[1];
   assign if1.we    = b_we[1];
   assign if1.lock  = b_lock[1];
   assign if1.addr  = b_addr[1];
   assign if1.wdata = b_wdata[1];

   mem_arbiter #(.ADDR_W(24), .DATA_W(16), .MAX_LOCK(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .io_p0       (if0),
      .io_p1       (if1),
      .o_mem_addr  (o_mem_addr),
      .o_mem_wdata (o_mem_wdata),
      .o_mem_we    (o_mem_we),
      .i_mem_rdata (i_mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] model_rd(input logic [23:0] a);
      if (a == 24'h000010) return 16'hBEEF;
      return {a[7:0], ~a[7:0]};
   endfunction

   // Memory model: one-cycle synchronous read
   always @(posedge clk) begin
      i_mem_rdata <= model_rd(o_mem_addr);
      cyc <= cyc + 1;
   end

   // Observer, sampled away from the active edge
   always @(negedge clk) begin
      if (if0.gnt && if1.gnt) n_both++;
      if (if0.rvalid && if1.rvalid) n_both++;
      if (o_mem_we && !(if0.gnt || if1.gnt)) n_stray_we++;
      if (!rst_n && o_mem_we) n_stray_we++;
      if (o_mem_we) n_we++;
      if (if1.rvalid) n_rv1++;
      if (if0.gnt) begin gq.push_back(0); gt.push_back(cyc); end
      if (if1.gnt) begin gq.push_back(1); gt.push_back(cyc); end
      if (if0.rvalid) rq0.push_back(if0.rdata);
      if (if1.rvalid) rq1.push_back(if1.rdata);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic gnt_of(input int p);
      return (p == 0) ? if0.gnt : if1.gnt;
   endfunction

   // Issue n transactions on port p, each held until its grant
   task automatic run_port(input int p, input int n, input logic we, input logic lk,
                           input logic [23:0] base);
      for (int i = 0; i < n; i++) begin
         bit got;
         b_req[p]   = 1'b1;
         b_we[p]    = we;
         b_lock[p]  = lk;
         b_addr[p]  = base + 24'(i);
         b_wdata[p] = base[15:0] + 16'(i) + 16'h7000;
         got = 1'b0;
         for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (gnt_of(p)) got = 1'b1;
         end
         if (!got) chk("gnt_timeout", 32'(p), 32'hFFFF);
         @(posedge clk); #1;
      end
      b_req[p]  = 1'b0;
      b_we[p]   = 1'b0;
      b_lock[p] = 1'b0;
   endtask

   task automatic clear_logs();
      gq.delete();
      gt.delete();
      rq0.delete();
      rq1.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_gnt",    {30'd0, if1.gnt, if0.gnt}, 32'h0);
      chk("rst_rvalid", {30'd0, if1.rvalid, if0.rvalid}, 32'h0);
      chk("rst_rdata",  {if1.rdata, if0.rdata}, 32'h0);
      chk("rst_mem",    {7'd0, o_mem_we, o_mem_addr}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single read on port 0
      b_req[0] = 1'b1; b_we[0] = 1'b0; b_addr[0] = 24'h000010;
      @(negedge clk);
      chk("rd_no_early_gnt", {31'd0, if0.gnt}, 32'h0);
      @(negedge clk);
      chk("rd_gnt0", {30'd0, if1.gnt, if0.gnt}, 32'h1);
      chk("rd_addr", {8'd0, o_mem_addr}, 32'h000010);
      chk("rd_we",   {31'd0, o_mem_we}, 32'h0);
      @(posedge clk); #1;
      b_req[0] = 1'b0;
      @(negedge clk);
      chk("rd_rvalid_wait", {31'd0, if0.rvalid}, 32'h0);
      chk("rd_bus_idle",    {8'd0, o_mem_addr}, 32'h0);
      @(negedge clk);
      chk("rd_rvalid0", {31'd0, if0.rvalid}, 32'h1);
      chk("rd_rdata0",  {16'd0, if0.rdata}, 32'hBEEF);
      chk("rd_p1_quiet", {15'd0, if1.rvalid, if1.rdata}, 32'h0);
      @(negedge clk);
      chk("rd_pulse",     {31'd0, if0.rvalid}, 32'h0);
      chk("rd_hold_data", {16'd0, if0.rdata}, 32'hBEEF);

      // Single write on port 1
      @(posedge clk); #1;
      n_we = 0;
      b_req[1] = 1'b1; b_we[1] = 1'b1; b_addr[1] = 24'h000100; b_wdata[1] = 16'h1234;
      @(negedge clk);
      chk("wr_no_early_we", {31'd0, o_mem_we}, 32'h0);
      @(negedge clk);
      chk("wr_gnt1",  {30'd0, if1.gnt, if0.gnt}, 32'h2);
      chk("wr_we",    {31'd0, o_mem_we}, 32'h1);
      chk("wr_addr",  {8'd0, o_mem_addr}, 32'h000100);
      chk("wr_wdata", {16'd0, o_mem_wdata}, 32'h1234);
      @(posedge clk); #1;
      b_req[1] = 1'b0; b_we[1] = 1'b0;
      repeat (3) @(negedge clk);
      chk("wr_we_once", 32'(n_we), 32'd1);
      chk("wr_no_rvalid", 32'(rq1.size()), 32'd0);

      // Both ports, 4 reads each: strict alternation starting at port 0
      @(posedge clk); #1;
      clear_logs();
      fork
         run_port(0, 4, 1'b0, 1'b0, 24'h000020);
         run_port(1, 4, 1'b0, 1'b0, 24'h000040);
      join
      repeat (4) @(negedge clk);
      chk("alt_count", 32'(gq.size()), 32'd8);
      for (int i = 0; i < 8; i++)
         if (i < gq.size()) chk("alt_order", 32'(gq[i]), 32'(i % 2));
      chk("alt_rv0_count", 32'(rq0.size()), 32'd4);
      chk("alt_rv1_count", 32'(rq1.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < rq0.size()) chk("alt_rdata0", 32'(rq0[i]), 32'(model_rd(24'h20 + 24'(i))));
         if (i < rq1.size()) chk("alt_rdata1", 32'(rq1[i]), 32'(model_rd(24'h40 + 24'(i))));
      end

      // Locked port 0 (6 writes) against port 1 (3 writes): lock expires after 4
      @(posedge clk); #1;
      clear_logs();
      fork
         run_port(0, 6, 1'b1, 1'b1, 24'h000080);
         run_port(1, 3, 1'b1, 1'b0, 24'h000090);
      join
      repeat (3) @(negedge clk);
      chk("lock_count", 32'(gq.size()), 32'd9);
      begin
         int exp_head[6] = '{0, 0, 0, 0, 1, 0};
         int n0;
         n0 = 0;
         for (int i = 0; i < 6; i++)
            if (i < gq.size()) chk("lock_order", 32'(gq[i]), 32'(exp_head[i]));
         for (int i = 0; i < gq.size(); i++) if (gq[i] == 0) n0++;
         chk("lock_n_gnt0", 32'(n0), 32'd6);
      end

      // Lone back-to-back writer: a grant every second cycle
      @(posedge clk); #1;
      clear_logs();
      run_port(0, 4, 1'b1, 1'b0, 24'h0000C0);
      repeat (3) @(negedge clk);
      chk("b2b_count", 32'(gt.size()), 32'd4);
      for (int i = 1; i < 4; i++)
         if (i < gt.size()) chk("b2b_spacing", gt[i] - gt[i-1], 32'd2);

      // Reset during the data phase of a port-1 read
      @(posedge clk); #1;
      n_rv1 = 0;
      b_req[1] = 1'b1; b_we[1] = 1'b0; b_addr[1] = 24'h000050;
      @(negedge clk);
      @(negedge clk);
      chk("rst_rd_gnt1", {31'd0, if1.gnt}, 32'h1);
      @(posedge clk); #1;
      b_req[1] = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rdata", {if1.rdata, if0.rdata}, 32'h0);
      chk("async_flags", {28'd0, if1.rvalid, if0.rvalid, if1.gnt, if0.gnt}, 32'h0);
      chk("async_mem",   {7'd0, o_mem_we, o_mem_addr}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_no_rvalid1", 32'(n_rv1), 32'd0);

      // First tie after reset goes to port 0, then alternates
      @(posedge clk); #1;
      clear_logs();
      fork
         run_port(0, 2, 1'b1, 1'b0, 24'h0000A0);
         run_port(1, 2, 1'b1, 1'b0, 24'h0000B0);
      join
      repeat (3) @(negedge clk);
      chk("post_rst_count", 32'(gq.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < gq.size()) chk("post_rst_order", 32'(gq[i]), 32'(i % 2));

      chk("gnt_rvalid_exclusive", 32'(n_both), 32'd0);
      chk("stray_mem_we", 32'(n_stray_we), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port instruction/data memory between the processor core (port 0) and the IR/servo peripheral engine (port 1). Round-robin arbitration, optional bounded locking for read-modify-write sequences, fixed one-cycle memory read latency hidden behind a grant/rvalid handshake. Sits between the requesters and the memory block; the memory sees exactly one master.

## Interface
- ADDR_W, 24, address width (matches core `mem_addr`)
- DATA_W, 16, data width
- MAX_LOCK, 4, max consecutive transactions a locked port may take before forced release (≥1)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  transaction request, held until matching gnt
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- lock0 / lock1  in  1  keep grant for the next transaction of this port
- addr0 / addr1  in  ADDR_W  transaction address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted and presented to memory this cycle
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata valid
- rdata0 / rdata1  out  DATA_W  registered read data, holds until next rvalid of that port
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  DATA_W  memory read data, valid one cycle after address presented

## Operation
- States: IDLE, ISSUE, RDATA.
- IDLE: if no req, stay. Else pick winner, latch its we/addr/wdata/lock into internal registers, go ISSUE.
- Winner rule: only one req → that port. Both req → port != last_grant. Locked owner (lock_active, owner, lock_cnt < MAX_LOCK) with its req high → owner wins unconditionally.
- ISSUE: mem_addr/mem_wdata/mem_we driven from latched registers; gnt of winner high; last_grant <= winner. Write → IDLE. Read → RDATA.
- RDATA: capture mem_rdata into winner's rdata; rvalid of winner high next cycle (registered). → IDLE.
- Lock: at ISSUE, if latched lock=1 then lock_active<=1, owner<=winner, lock_cnt<=lock_cnt+1; if lock=0 then lock_active<=0, lock_cnt<=0. When lock_cnt reaches MAX_LOCK, lock_active cleared and normal round-robin applies (other port wins if requesting). Owner dropping req in IDLE while locked: lock released, counter cleared.
- Outside ISSUE: mem_we=0, mem_addr=0, mem_wdata=0. gnt and rvalid never high for both ports in one cycle.
- Requesters must not change addr/we/wdata between req assertion and gnt; after gnt they may present the next request in the following cycle.

## Timing
- Reset (async, rst_n=0): state IDLE, all outputs 0, rdata0/1=0, last_grant=1 (port 0 wins first tie), lock_active=0, lock_cnt=0.
- Read: req in cycle N (IDLE) → gnt + mem_addr in N+1 → mem_rdata in N+2 → rvalid/rdata in N+3. One read per 3 cycles.
- Write: req in N → gnt + mem_we in N+1 → IDLE in N+2. One write per 2 cycles.
- Request asserted while busy is held and arbitrated at the next IDLE cycle.
- Reset mid-transaction: in-flight read produces no rvalid; no mem_we after rst_n falls.
- Simultaneous reqs repeated: strict alternation 0,1,0,1…

## Test plan
- Reset then req0 read addr 0x000010, mem returns 0xBEEF → gnt0 at N+1 with mem_addr=0x000010, rvalid0 at N+3 with rdata0=0xBEEF; port 1 outputs stay 0.
- req1 write addr 0x000100 data 0x1234 → gnt1 and mem_we=1, mem_addr=0x000100, mem_wdata=0x1234 for exactly one cycle; mem_we=0 otherwise.
- req0 and req1 both held for 4 reads each → grant order 0,1,0,1,0,1,0,1; each rvalid on correct port with correct data.
- req0 with lock0=1 for 6 writes, req1 held throughout, MAX_LOCK=4 → four consecutive gnt0, then gnt1, then remaining gnt0s interleaved.
- Read granted to port 1, rst_n pulled low in RDATA cycle → rvalid1 never asserts, all outputs 0 asynchronously, first tie after reset goes to port 0.
- Back-to-back writes from port 0 only → gnt0 every 2nd cycle, last_grant not blocking a lone requester.
